// File: rtl/mult_feeder.sv
// mult_feeder: operand-pair FIFO feeding a start/ready multiplier, holding each result until accepted.
// Define MULT_FEEDER_TIMEOUT_EN to abandon a pair after TIMEOUT cycles in WAIT and raise a sticky out_error.
module mult_feeder #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_x,
    input  logic [WIDTH-1:0]         in_y,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_x,
    output logic [WIDTH-1:0]         mul_y,
    input  logic                     mul_ready,
    input  logic [2*WIDTH-1:0]       mul_product,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*WIDTH-1:0]       out_product,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     out_error
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     x_mem_q [DEPTH];
    logic [WIDTH-1:0]     y_mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q, count_d;
    logic                 push, pop;
    logic                 mul_start_q, out_valid_q;
    logic [WIDTH-1:0]     mul_x_q, mul_y_q;
    logic [2*WIDTH-1:0]   out_product_q;

    assign in_ready    = count_q < FULL;
    assign push        = in_valid && in_ready;
    // The head is popped on the edge that enters ISSUE, so mul_x/mul_y are valid during ISSUE.
    assign pop         = (count_q != '0) && (state_q == IDLE || (state_q == HOLD && out_ready));
    assign count_d     = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign count       = count_q;
    assign busy        = state_q != IDLE;
    assign mul_start   = mul_start_q;
    assign mul_x       = mul_x_q;
    assign mul_y       = mul_y_q;
    assign out_valid   = out_valid_q;
    assign out_product = out_product_q;

`ifdef MULT_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;
    logic          err_q;
    assign out_error = err_q;
`else
    // Constant 0 for any legal TIMEOUT.
    assign out_error = TIMEOUT < 0;
`endif

    always_ff @(posedge clk_in) begin
        if (push) begin
            x_mem_q[wr_ptr_q] <= in_x;
            y_mem_q[wr_ptr_q] <= in_y;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            mul_start_q   <= 1'b0;
            mul_x_q       <= '0;
            mul_y_q       <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
`ifdef MULT_FEEDER_TIMEOUT_EN
            tmo_q         <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            count_q     <= count_d;
            mul_start_q <= pop;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                mul_x_q  <= x_mem_q[rd_ptr_q];
                mul_y_q  <= y_mem_q[rd_ptr_q];
            end
            case (state_q)
                IDLE: if (pop) state_q <= ISSUE;
                ISSUE: begin
                    state_q <= WAIT;
`ifdef MULT_FEEDER_TIMEOUT_EN
                    tmo_q   <= '0;
`endif
                end
                WAIT: begin
                    if (mul_ready) begin
                        out_product_q <= mul_product;
                        out_valid_q   <= 1'b1;
                        state_q       <= HOLD;
                    end
`ifdef MULT_FEEDER_TIMEOUT_EN
                    else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else tmo_q <= tmo_q + TW'(1);
`endif
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= pop ? ISSUE : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
